alu_mac: RTL

Parametrised, multi-cycle accumulator ALU for the picoMips datapath; it succeeds the single-cycle 8-bit ALU. It supports load, add, fixed-point multiply and multiply-accumulate on a W-bit signed accumulator, with operands taken from the immediate, the switches or the register file. Multiplies run on an iterative shift-add core under a Start/Busy/Done handshake, which lets W grow without a wide combinational multiplier. The block sits between the decoder (Op, Sel, Start) and the register file/output port (ACC).

---
 rtl/alu_mac_pkg.sv | 24 ++
 rtl/alu_mac_seq_mult.sv | 52 +++++
 rtl/alu_mac.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_mac_pkg.sv
// Shared types for the alu_mac accumulator ALU: opcode, operand-select and FSM state encodings.
package alu_mac_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_MUL  = 2'b10,
    OP_MAC  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SEL_IMM  = 2'b00,
    SEL_SW   = 2'b01,
    SEL_REG  = 2'b10,
    SEL_ZERO = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MULT  = 2'b01,
    WRITE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mac_seq_mult.sv
// Iterative W-cycle signed shift-add multiplier; the multiplier MSB is weighted negatively
// on the last iteration so the 2W-bit product is exact for all signed operand pairs.
module seq_mult #(
  parameter int W = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] product_reg;
  logic [CW-1:0]  count_reg;
  logic           busy_reg;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg   <= {{W{a[W-1]}}, a};
      mplier_reg  <= b;
      product_reg <= '0;
      count_reg   <= CW'(W - 1);
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      // count 0 means the sign bit of the multiplier: subtract instead of add
      if (mplier_reg[0])
        product_reg <= (count_reg == '0) ? product_reg - mcand_reg : product_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (count_reg == '0)
        busy_reg <= 1'b0;
      else
        count_reg <= count_reg - 1'b1;
    end
  end

  assign busy    = busy_reg;
  assign product = product_reg;

endmodule

// File: rtl/alu_mac.sv
// W-bit signed accumulator ALU (LOAD/ADD/MUL/MAC) with a multi-cycle multiply path.
// Define ALU_SAT_EN to clamp ADD/MUL/MAC results and report clipping on Sat; otherwise results wrap.
module alu_mac
  import alu_mac_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 0
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic [W-1:0] Imm,
  input  logic [W-1:0] SW,
  input  logic [W-1:0] RegData,
  input  logic [1:0]   Sel,
  input  logic [1:0]   Op,
  input  logic         Start,
  output logic         Busy,
  output logic         Done,
  output logic         Sat,
  output logic [W-1:0] ACC
);

  localparam int CW = $clog2(W);
  localparam int XW = 2 * W + 1;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [W-1:0]   acc_reg;
  logic [W-1:0]   snap_reg;
  op_t            op_reg;
  logic           done_reg;

  logic [W-1:0]   b_sel;
  logic           accept_simple;
  logic           mult_start;
  logic [W-1:0]   mult_a, mult_b;
  logic           mult_busy;
  logic [2*W-1:0] mult_product;

  logic signed [2*W-1:0] shifted;
  logic signed [XW-1:0]  add_ext, write_ext, res_ext;
  logic [W-1:0]          res_w;
  logic                  res_clip;

  always_comb begin
    b_sel = '0;
    case (sel_t'(Sel))
      SEL_IMM:  b_sel = Imm;
      SEL_SW:   b_sel = SW;
      SEL_REG:  b_sel = RegData;
      default:  b_sel = '0;
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (mult_start)
        count_reg <= CW'(W - 1);
      else if (state_reg == MULT && count_reg != '0)
        count_reg <= count_reg - 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start && (op_t'(Op) == OP_MUL || op_t'(Op) == OP_MAC)) state_next = MULT;
      MULT:    if (count_reg == '0) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept_simple = 1'b0;
    mult_start    = 1'b0;
    mult_a        = acc_reg;
    mult_b        = b_sel;
    if (state_reg == IDLE && Start) begin
      if (op_t'(Op) == OP_LOAD || op_t'(Op) == OP_ADD)
        accept_simple = 1'b1;
      else
        mult_start = 1'b1;
    end
    if (op_t'(Op) == OP_MAC) begin
      mult_a = b_sel;
      mult_b = Imm;
    end
  end

  seq_mult #(.W(W)) u_seq_mult (
    .Clock   (Clock),
    .nReset  (nReset),
    .start   (mult_start),
    .a       (mult_a),
    .b       (mult_b),
    .busy    (mult_busy),
    .product (mult_product)
  );

  // Everything is widened to 2W+1 bits so a single reduction stage serves all ops
  assign shifted   = $signed(mult_product) >>> FRAC;
  assign add_ext   = XW'($signed(acc_reg)) + XW'($signed(b_sel));
  assign write_ext = (op_reg == OP_MAC) ? XW'($signed(snap_reg)) + XW'(shifted) : XW'(shifted);
  assign res_ext   = (state_reg == WRITE) ? write_ext : add_ext;

`ifdef ALU_SAT_EN
  localparam logic signed [XW-1:0] MAX_X = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  logic sat_reg;

  always_comb begin
    res_w    = res_ext[W-1:0];
    res_clip = 1'b0;
    if (res_ext > MAX_X) begin
      res_w    = MAX_X[W-1:0];
      res_clip = 1'b1;
    end else if (res_ext < MIN_X) begin
      res_w    = MIN_X[W-1:0];
      res_clip = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      sat_reg <= 1'b0;
    else if (accept_simple)
      sat_reg <= (op_t'(Op) == OP_ADD) ? res_clip : 1'b0;
    else if (state_reg == WRITE)
      sat_reg <= res_clip;
  end

  assign Sat = sat_reg;
`else
  logic unused_res;
  assign res_w      = res_ext[W-1:0];
  assign res_clip   = 1'b0;
  assign unused_res = ^{res_ext[XW-1:W], res_clip};
  assign Sat        = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_reg  <= '0;
      snap_reg <= '0;
      op_reg   <= OP_LOAD;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept_simple) begin
        acc_reg  <= (op_t'(Op) == OP_LOAD) ? b_sel : res_w;
        done_reg <= 1'b1;
      end
      if (mult_start) begin
        op_reg   <= op_t'(Op);
        snap_reg <= acc_reg;
      end
      if (state_reg == WRITE) begin
        acc_reg  <= res_w;
        done_reg <= 1'b1;
      end
    end
  end

  logic unused_busy;
  assign unused_busy = mult_busy;

  assign Busy = (state_reg != IDLE);
  assign Done = done_reg;
  assign ACC  = acc_reg;

endmodule
